// File: rtl/cnn_window_fetch.sv
// Unpacks UART bytes into a pixel RAM and streams KxK windows from it to a CNN core.
// Optional stride select port is added when CNN_WF_STRIDE_EN is defined.
module cnn_window_fetch #(
  parameter int unsigned IMG_W  = 28,
  parameter int unsigned IMG_H  = 28,
  parameter int unsigned K      = 3,
  parameter int unsigned PIX_W  = 1,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_vld,
  output logic              rx_rdy,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [PIX_W-1:0]  ram_wdata,
  output logic [ADDR_W-1:0] ram_raddr,
  input  logic [PIX_W-1:0]  ram_rdata,
  input  logic              core_bsy,
`ifdef CNN_WF_STRIDE_EN
  input  logic              stride_sel,
`endif
  output logic [PIX_W-1:0]  pix_out,
  output logic              pix_vld,
  output logic              win_first,
  output logic              win_last,
  output logic              frame_done
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned NPIX  = IMG_W * IMG_H;
  localparam int unsigned PPB   = 8 / PIX_W;
  localparam int unsigned KW    = (K > 1) ? $clog2(K) : 1;

  localparam logic [CNT_W-1:0]  NPIX_M1 = CNT_W'(NPIX - 1);
  localparam logic [2:0]        PPB_M1  = 3'(PPB - 1);
  localparam logic [ADDR_W-1:0] W_A     = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] K_M1_A  = ADDR_W'(K - 1);
  localparam logic [ADDR_W-1:0] C_MAX   = ADDR_W'(IMG_W - K);
  localparam logic [ADDR_W-1:0] R_MAX   = ADDR_W'(IMG_H - K);
  localparam logic [KW-1:0]     K_M1    = KW'(K - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_READ = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]        state, nxt_state;
  logic [ADDR_W-1:0] org_r, org_c, nxt_r, nxt_c;
  logic [KW-1:0]     win_i, win_j, nxt_i, nxt_j;
  logic [ADDR_W-1:0] stride, need, nxt_raddr;

  logic [CNT_W-1:0]  wr_cnt;
  logic [7:0]        byte_buf, wr_src;
  logic [2:0]        px_left;
  logic              full, done_seen;
  logic              acc, wr_act, wr_last, rd_done;

`ifdef CNN_WF_STRIDE_EN
  logic stride_q;

  // Stride is latched once per frame, when the first pixel lands
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stride_q <= 1'b0;
    else if (state == S_IDLE && nxt_state == S_WAIT)
      stride_q <= stride_sel;
  end

  assign stride = stride_q ? ADDR_W'(2) : ADDR_W'(1);
`else
  assign stride = ADDR_W'(1);
`endif

  assign acc     = rx_vld & rx_rdy;
  assign wr_act  = acc | (px_left != 3'd0);
  assign wr_last = wr_act & (wr_cnt == NPIX_M1);
  assign rd_done = (state == S_DONE);
  assign wr_src  = acc ? rx_data : byte_buf;
  assign need    = (org_r + K_M1_A) * W_A + org_c + K_M1_A;
  assign pix_out = pix_vld ? ram_rdata : '0;

  // Write side: first pixel comes straight from rx_data, the rest from the shift buffer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_rdy    <= 1'b1;
      ram_we    <= 1'b0;
      ram_waddr <= '0;
      ram_wdata <= '0;
      wr_cnt    <= '0;
      byte_buf  <= '0;
      px_left   <= '0;
      full      <= 1'b0;
      done_seen <= 1'b0;
    end else begin
      ram_we <= 1'b0;
      if (wr_act) begin
        ram_we    <= 1'b1;
        ram_waddr <= wr_cnt[ADDR_W-1:0];
        ram_wdata <= wr_src[PIX_W-1:0];
        byte_buf  <= wr_src >> PIX_W;
        if (wr_last) begin
          px_left <= '0;
          if (done_seen || rd_done) begin
            wr_cnt    <= '0;
            rx_rdy    <= 1'b1;
            done_seen <= 1'b0;
          end else begin
            wr_cnt <= wr_cnt + CNT_W'(1);
            full   <= 1'b1;
            rx_rdy <= 1'b0;
          end
        end else begin
          wr_cnt  <= wr_cnt + CNT_W'(1);
          px_left <= acc ? PPB_M1 : px_left - 3'd1;
          rx_rdy  <= acc ? (PPB_M1 == 3'd0) : (px_left == 3'd1);
          if (rd_done) done_seen <= 1'b1;
        end
      end else if (rd_done) begin
        // Reads can finish before the last pixel arrives when the stride skips the tail
        if (full) begin
          wr_cnt <= '0;
          full   <= 1'b0;
          rx_rdy <= 1'b1;
        end else begin
          done_seen <= 1'b1;
        end
      end
    end
  end

  // Read FSM next-state and window/origin stepping
  always_comb begin
    nxt_state = state;
    nxt_r     = org_r;
    nxt_c     = org_c;
    nxt_i     = win_i;
    nxt_j     = win_j;
    case (state)
      S_IDLE: begin
        if (ram_we && ram_waddr == '0) begin
          nxt_state = S_WAIT;
          nxt_r     = '0;
          nxt_c     = '0;
        end
      end
      S_WAIT: begin
        if ((wr_cnt > {1'b0, need}) && !core_bsy) begin
          nxt_state = S_READ;
          nxt_i     = '0;
          nxt_j     = '0;
        end
      end
      S_READ: begin
        if (win_j == K_M1) begin
          nxt_j = '0;
          if (win_i == K_M1) begin
            nxt_i = '0;
            if (org_c + stride > C_MAX) begin
              nxt_c = '0;
              if (org_r + stride > R_MAX) begin
                nxt_state = S_DONE;
                nxt_r     = '0;
              end else begin
                nxt_r     = org_r + stride;
                nxt_state = S_WAIT;
              end
            end else begin
              nxt_c     = org_c + stride;
              nxt_state = S_WAIT;
            end
          end else begin
            nxt_i = win_i + KW'(1);
          end
        end else begin
          nxt_j = win_j + KW'(1);
        end
      end
      S_DONE:  nxt_state = S_IDLE;
      default: nxt_state = S_IDLE;
    endcase
  end

  assign nxt_raddr = (nxt_r + ADDR_W'(nxt_i)) * W_A + nxt_c + ADDR_W'(nxt_j);

  // Read FSM state and registered read-side outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      org_r      <= '0;
      org_c      <= '0;
      win_i      <= '0;
      win_j      <= '0;
      ram_raddr  <= '0;
      pix_vld    <= 1'b0;
      win_first  <= 1'b0;
      win_last   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state <= nxt_state;
      org_r <= nxt_r;
      org_c <= nxt_c;
      win_i <= nxt_i;
      win_j <= nxt_j;
      if (nxt_state == S_READ) ram_raddr <= nxt_raddr;
      pix_vld    <= (state == S_READ);
      win_first  <= (state == S_READ) && (win_i == '0) && (win_j == '0);
      win_last   <= (state == S_READ) && (win_i == K_M1) && (win_j == K_M1);
      frame_done <= (state == S_DONE);
    end
  end

endmodule

// File: tb/tb_cnn_window_fetch.sv
// Directed bench for cnn_window_fetch on a 5x5, K=3, 1-bit image with a behavioural pixel RAM.
module tb_cnn_window_fetch;

  localparam int unsigned AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    rx_data;
  logic          rx_vld;
  logic          rx_rdy;
  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [0:0]    ram_wdata;
  logic [AW-1:0] ram_raddr;
  logic [0:0]    ram_rdata = 1'b0;
  logic          core_bsy;
  logic [0:0]    pix_out;
  logic          pix_vld, win_first, win_last, frame_done;
`ifdef CNN_WF_STRIDE_EN
  logic          stride_sel = 1'b0;
`endif

  cnn_window_fetch #(.IMG_W(5), .IMG_H(5), .K(3), .PIX_W(1), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_vld(rx_vld), .rx_rdy(rx_rdy),
    .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
    .ram_raddr(ram_raddr), .ram_rdata(ram_rdata),
    .core_bsy(core_bsy),
`ifdef CNN_WF_STRIDE_EN
    .stride_sel(stride_sel),
`endif
    .pix_out(pix_out), .pix_vld(pix_vld),
    .win_first(win_first), .win_last(win_last), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  logic [0:0] mem [0:31];
  always @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
    ram_rdata <= mem[ram_raddr];
  end

  logic [7:0] fb [4] = '{8'hA5, 8'h3C, 8'h96, 8'hF1};

  function automatic logic img_bit(input int k);
    logic [7:0] b;
    b = fb[k / 8];
    return b[k % 8];
  endfunction

  // Observation logs, sampled on the falling edge
  int n_we = 0, n_vld = 0, n_done = 0, n_first = 0, n_last = 0;
  int wa_q[$], wd_q[$], ra_q[$], px_q[$], fi_q[$], la_q[$];
  logic [AW-1:0] prev_raddr = '0;

  always @(negedge clk) begin
    if (ram_we) begin
      n_we++;
      wa_q.push_back(int'(ram_waddr));
      wd_q.push_back(int'(ram_wdata));
    end
    if (pix_vld) begin
      n_vld++;
      ra_q.push_back(int'(prev_raddr));
      px_q.push_back(int'(pix_out));
      fi_q.push_back(int'(win_first));
      la_q.push_back(int'(win_last));
      if (win_first) n_first++;
      if (win_last) n_last++;
    end
    if (frame_done) n_done++;
    prev_raddr = ram_raddr;
  end

  int checks = 0, failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    @(negedge clk);
    while (!rx_rdy && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("send_rdy", 32'(rx_rdy), 32'd1);
    rx_data = b;
    rx_vld  = 1'b1;
    @(posedge clk);
    #1 rx_vld = 1'b0;
  endtask

  task automatic wait_done(input int target, input string tag);
    int t;
    t = 0;
    while (n_done < target && t < 800) begin
      @(negedge clk);
      t++;
    end
    check(tag, 32'(n_done >= target), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_rdy"}, 32'(rx_rdy), 32'd1);
    check({tag, "_ram_we"}, 32'(ram_we), 32'd0);
    check({tag, "_waddr"}, 32'(ram_waddr), 32'd0);
    check({tag, "_raddr"}, 32'(ram_raddr), 32'd0);
    check({tag, "_wdata"}, 32'(ram_wdata), 32'd0);
    check({tag, "_pix_out"}, 32'(pix_out), 32'd0);
    check({tag, "_pix_vld"}, 32'(pix_vld), 32'd0);
    check({tag, "_win_first"}, 32'(win_first), 32'd0);
    check({tag, "_win_last"}, 32'(win_last), 32'd0);
    check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
  endtask

  initial begin
    int we0, vb, db, fb0, n_chk, idx, a;
    for (int m = 0; m < 32; m++) mem[m] = 1'b0;
    rst = 1'b1; rx_vld = 1'b0; rx_data = 8'h00; core_bsy = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rst = 1'b0;

    // Frame 1: free-running core, with a byte offered while the unpacker is busy
    send_byte(fb[0]);
    @(negedge clk);
    check("rdy_low_unpack", 32'(rx_rdy), 32'd0);
    rx_data = 8'hFF;
    rx_vld  = 1'b1;
    @(posedge clk);
    #1 rx_vld = 1'b0;
    for (int k = 1; k < 4; k++) send_byte(fb[k]);
    wait_done(1, "f1_done_timeout");
    repeat (5) @(negedge clk);

    check("f1_writes", 32'(n_we), 32'd25);
    n_chk = (wa_q.size() < 25) ? wa_q.size() : 25;
    for (int k = 0; k < n_chk; k++) begin
      check($sformatf("f1_waddr_%0d", k), 32'(wa_q[k]), 32'(k));
      check($sformatf("f1_wdata_%0d", k), 32'(wd_q[k]), 32'(img_bit(k)));
    end
    check("f1_pix_vld", 32'(n_vld), 32'd81);
    check("f1_windows_first", 32'(n_first), 32'd9);
    check("f1_windows_last", 32'(n_last), 32'd9);
    check("f1_frame_done", 32'(n_done), 32'd1);
    n_chk = (ra_q.size() < 81) ? ra_q.size() : 81;
    for (int w = 0; w < 9; w++)
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++) begin
          idx = w * 9 + i * 3 + j;
          a   = ((w / 3) + i) * 5 + (w % 3) + j;
          if (idx < n_chk) begin
            check($sformatf("f1_raddr_%0d", idx), 32'(ra_q[idx]), 32'(a));
            check($sformatf("f1_pix_%0d", idx), 32'(px_q[idx]), 32'(img_bit(a)));
            check($sformatf("f1_first_%0d", idx), 32'(fi_q[idx]), 32'(i == 0 && j == 0));
            check($sformatf("f1_last_%0d", idx), 32'(la_q[idx]), 32'(i == 2 && j == 2));
          end
        end

    // Frame 2: core busy holds the first window until it drops
    core_bsy = 1'b1;
    we0 = n_we;
    vb  = n_vld;
    for (int k = 0; k < 4; k++) send_byte(fb[k]);
    repeat (20) @(negedge clk);
    check("f2_writes", 32'(n_we - we0), 32'd25);
    check("f2_no_read_busy", 32'(n_vld - vb), 32'd0);
    check("f2_rdy_low_full", 32'(rx_rdy), 32'd0);
    check("f2_no_done_busy", 32'(n_done), 32'd1);
    core_bsy = 1'b0;
    @(negedge clk);
    check("f2_raddr_first", 32'(ram_raddr), 32'd0);
    check("f2_vld_not_yet", 32'(pix_vld), 32'd0);
    @(negedge clk);
    check("f2_vld_first", 32'(pix_vld), 32'd1);
    check("f2_win_first", 32'(win_first), 32'd1);
    check("f2_pix0", 32'(pix_out), 32'(img_bit(0)));
    wait_done(2, "f2_done_timeout");
    repeat (3) @(negedge clk);
    check("f2_pix_vld", 32'(n_vld - vb), 32'd81);
    check("f2_rdy_after_done", 32'(rx_rdy), 32'd1);

    // Frame 3: reset lands inside the third window
    core_bsy = 1'b1;
    for (int k = 0; k < 4; k++) send_byte(fb[k]);
    repeat (3) @(negedge clk);
    fb0 = n_first;
    db  = n_done;
    core_bsy = 1'b0;
    idx = 0;
    while (n_first - fb0 < 3 && idx < 200) begin
      @(negedge clk);
      idx++;
    end
    check("f3_reach_win3", 32'(n_first - fb0), 32'd3);
    #2 rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    we0 = n_we;
    vb  = n_vld;
    repeat (12) @(negedge clk);
    check("post_rst_no_vld", 32'(n_vld - vb), 32'd0);
    check("post_rst_no_we", 32'(n_we - we0), 32'd0);
    check("post_rst_no_done", 32'(n_done - db), 32'd0);
    send_byte(8'h01);
    check("new_frame_we", 32'(ram_we), 32'd1);
    check("new_frame_addr0", 32'(ram_waddr), 32'd0);
    check("new_frame_data", 32'(ram_wdata), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
